// File: rtl/resolver_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package resolver_pkg;

    localparam int GUARD_BITS = 2;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/compressor_4_2_n_bit.sv
// Bit-parallel 4:2 compressor; outputs are kept mod 2^INPUT_WIDTH (top column carries dropped).
module compressor_4_2_n_bit #(
    parameter int INPUT_WIDTH = 8,
    parameter bit SHIFT_CARRY = 1'b1
) (
    input  logic [INPUT_WIDTH-1:0] a_i,
    input  logic [INPUT_WIDTH-1:0] b_i,
    input  logic [INPUT_WIDTH-1:0] c_i,
    input  logic [INPUT_WIDTH-1:0] d_i,
    output logic [INPUT_WIDTH-1:0] sum_o,
    output logic [INPUT_WIDTH-1:0] carry_o
);
    logic [INPUT_WIDTH-1:0] s1;
    logic [INPUT_WIDTH-1:0] cin;
    logic [INPUT_WIDTH-2:0] maj1;

    assign s1    = a_i ^ b_i ^ c_i;
    assign maj1  = (a_i[INPUT_WIDTH-2:0] & b_i[INPUT_WIDTH-2:0])
                 | (a_i[INPUT_WIDTH-2:0] & c_i[INPUT_WIDTH-2:0])
                 | (b_i[INPUT_WIDTH-2:0] & c_i[INPUT_WIDTH-2:0]);
    // First-level carries move one column up as the second adder's carry-in.
    assign cin   = {maj1, 1'b0};
    assign sum_o = s1 ^ d_i ^ cin;

    if (SHIFT_CARRY) begin : g_shift
        logic [INPUT_WIDTH-2:0] cmaj;
        assign cmaj    = (s1[INPUT_WIDTH-2:0] & d_i[INPUT_WIDTH-2:0])
                       | (s1[INPUT_WIDTH-2:0] & cin[INPUT_WIDTH-2:0])
                       | (d_i[INPUT_WIDTH-2:0] & cin[INPUT_WIDTH-2:0]);
        assign carry_o = {cmaj, 1'b0};
    end else begin : g_noshift
        assign carry_o = (s1 & d_i) | (s1 & cin) | (d_i & cin);
    end

endmodule

// File: rtl/carry_save_resolver.sv
// Carry-save group accumulator with chunked carry-propagate resolve.
// Optional saturation of the result to ACC_SIZE bits: define RESOLVER_SAT_EN.
module carry_save_resolver
    import resolver_pkg::*;
#(
    parameter int IN_SIZE  = 24,
    parameter int ACC_SIZE = 32,
    parameter int CHUNK    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IN_SIZE-1:0]  sum_i,
    input  logic [IN_SIZE-1:0]  carry_i,
    input  logic                last_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [ACC_SIZE-1:0] result_o,
    output logic                sat_o,
    output logic                valid_o,
    input  logic                ready_i
);
    localparam int W  = ACC_SIZE + GUARD_BITS;
    localparam int N  = num_chunks(W, CHUNK);
    localparam int CW = $clog2(N + 1);

    state_t                state_q, state_d;
    logic [W-1:0]          acc_s_q, acc_s_d;
    logic [W-1:0]          acc_c_q, acc_c_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cy_q, cy_d;
    logic [W-1:0]          res_w_q, res_w_d;
    logic [ACC_SIZE-1:0]   result_q, result_d;

    logic [W-1:0]          sum_ext, carry_ext, cmp_s, cmp_c;
    logic [CHUNK:0]        slice_sum;
    logic [W-1:0]          slice_hit, slice_bit;

    assign sum_ext   = {{(W-IN_SIZE){sum_i[IN_SIZE-1]}}, sum_i};
    assign carry_ext = {{(W-IN_SIZE){carry_i[IN_SIZE-1]}}, carry_i};

    compressor_4_2_n_bit #(
        .INPUT_WIDTH (W),
        .SHIFT_CARRY (1'b1)
    ) u_cmp (
        .a_i     (acc_s_q),
        .b_i     (acc_c_q),
        .c_i     (sum_ext),
        .d_i     (carry_ext),
        .sum_o   (cmp_s),
        .carry_o (cmp_c)
    );

    // Accumulators shift right one chunk per resolve cycle, so the active slice is always the low chunk.
    assign slice_sum = {1'b0, acc_s_q[CHUNK-1:0]} + {1'b0, acc_c_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, cy_q};

    for (genvar j = 0; j < W; j++) begin : g_bit
        assign slice_hit[j] = (cnt_q == CW'(j / CHUNK));
        assign slice_bit[j] = slice_sum[j % CHUNK];
    end

`ifdef RESOLVER_SAT_EN
    logic sat_q, sat_d;
    logic [W-ACC_SIZE:0] hi_bits;
    assign hi_bits = res_w_d[W-1:ACC_SIZE-1];
    assign sat_o   = sat_q;
`else
    assign sat_o   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_s_d  = acc_s_q;
        acc_c_d  = acc_c_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        res_w_d  = res_w_q;
        result_d = result_q;
`ifdef RESOLVER_SAT_EN
        sat_d    = sat_q;
`endif
        case (state_q)
            ST_ACC: begin
                if (valid_i) begin
                    acc_s_d = cmp_s;
                    acc_c_d = cmp_c;
                    if (last_i) state_d = ST_RES;
                end
            end
            ST_RES: begin
                acc_s_d = acc_s_q >> CHUNK;
                acc_c_d = acc_c_q >> CHUNK;
                cy_d    = slice_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                res_w_d = (res_w_q & ~slice_hit) | (slice_bit & slice_hit);
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = ST_OUT;
`ifdef RESOLVER_SAT_EN
                    // Guard bits plus ACC sign bit must agree, otherwise the value is out of range.
                    if ((&hi_bits) || !(|hi_bits)) begin
                        sat_d    = 1'b0;
                        result_d = res_w_d[ACC_SIZE-1:0];
                    end else begin
                        sat_d    = 1'b1;
                        result_d = res_w_d[W-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                                                : {1'b0, {(ACC_SIZE-1){1'b1}}};
                    end
`else
                    result_d = res_w_d[ACC_SIZE-1:0];
`endif
                end
            end
            ST_OUT: begin
                if (ready_i) begin
                    state_d = ST_ACC;
                    acc_s_d = '0;
                    acc_c_d = '0;
                    cnt_d   = '0;
                    cy_d    = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_ACC;
            acc_s_q  <= '0;
            acc_c_q  <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            res_w_q  <= '0;
            result_q <= '0;
`ifdef RESOLVER_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_s_q  <= acc_s_d;
            acc_c_q  <= acc_c_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            res_w_q  <= res_w_d;
            result_q <= result_d;
`ifdef RESOLVER_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign ready_o  = (state_q == ST_ACC);
    assign valid_o  = (state_q == ST_OUT);
    assign result_o = result_q;

endmodule

// File: tb/tb_carry_save_resolver.sv
// Directed + randomized bench for carry_save_resolver against an integer reference model.
module tb_carry_save_resolver;
    localparam int IN_SIZE  = 24;
    localparam int ACC_SIZE = 32;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [IN_SIZE-1:0]  sum_i = '0;
    logic [IN_SIZE-1:0]  carry_i = '0;
    logic                last_i = 1'b0;
    logic                valid_i = 1'b0;
    logic                ready_o;
    logic [ACC_SIZE-1:0] result_o;
    logic                sat_o;
    logic                valid_o;
    logic                ready_i = 1'b0;

    int     checks = 0;
    int     errors = 0;
    longint tot = 0;

    carry_save_resolver #(.IN_SIZE(IN_SIZE), .ACC_SIZE(ACC_SIZE), .CHUNK(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sum_i(sum_i), .carry_i(carry_i), .last_i(last_i),
        .valid_i(valid_i), .ready_o(ready_o), .result_o(result_o), .sat_o(sat_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [IN_SIZE-1:0] x);
        return longint'(signed'(x));
    endfunction

    // Group total taken mod 2^34 as a signed value, then wrapped or clamped to 32 bits.
    function automatic logic [32:0] model(input longint total);
        longint v;
        v = total & ((longint'(1) << 34) - 1);
        if (v >= (longint'(1) << 33)) v = v - (longint'(1) << 34);
`ifdef RESOLVER_SAT_EN
        if (v > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
        return {1'b0, 32'(v)};
    endfunction

    task automatic beat(input logic [IN_SIZE-1:0] s, input logic [IN_SIZE-1:0] c, input logic l);
        sum_i = s; carry_i = c; last_i = l; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; last_i = 1'b0;
        tot += sx(s) + sx(c);
    endtask

    // Called #1 after the last-beat edge; waits for valid_o, checks, then completes the handshake.
    task automatic expect_res(input string tag, input logic [31:0] er, input logic es);
        int lat;
        lat = 0;
        while (!valid_o && lat < 30) begin
            @(negedge clk_i);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd6);
        check({tag, "_result"}, 64'(result_o), 64'(er));
        check({tag, "_sat"}, 64'(sat_o), 64'(es));
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check({tag, "_ready_after"}, 64'({ready_o, valid_o}), 64'b10);
        tot = 0;
    endtask

    task automatic rand_group(input string tag, input int nb);
        logic [32:0] m;
        for (int i = 0; i < nb; i++)
            beat(24'($urandom), 24'($urandom), i == nb - 1);
        m = model(tot);
        expect_res(tag, m[31:0], m[32]);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        #1;
        check("reset_outputs", 64'({ready_o, valid_o, sat_o, result_o}), {30'd0, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;

        beat(24'd5, 24'd3, 1'b1);
        expect_res("single", 32'h0000_0008, 1'b0);

        beat(24'hFFFFFF, 24'hFFFFFE, 1'b0);
        beat(24'd10, 24'd0, 1'b0);
        beat(24'd0, 24'd4, 1'b1);
        check("three_ready_low", 64'(ready_o), 64'd0);
        expect_res("three", 32'h0000_000B, 1'b0);

        // Backpressure: hold ready_i low while offering beats that must be ignored.
        beat(24'd100, 24'hFFFFF0, 1'b1);
        n = 0;
        while (!valid_o && n < 30) begin @(negedge clk_i); n++; end
        check("bp_valid", 64'(valid_o), 64'd1);
        held = result_o;
        check("bp_result", 64'(held), 64'd84);
        sum_i = 24'd77; carry_i = 24'd1; last_i = 1'b1; valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            check("bp_stable", 64'({valid_o, ready_o, result_o}), {30'd0, 1'b1, 1'b0, held});
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;
        check("bp_ready_rise", 64'({ready_o, valid_o}), 64'b10);
        tot = 0;
        beat(24'd1, 24'd1, 1'b1);
        expect_res("bp_next", 32'h0000_0002, 1'b0);

        for (int i = 0; i < 128; i++) beat(24'h7FFFFF, 24'h7FFFFF, i == 127);
        expect_res("b128", 32'h7FFF_FF00, 1'b0);
        for (int i = 0; i < 129; i++) beat(24'h7FFFFF, 24'h7FFFFF, i == 128);
`ifdef RESOLVER_SAT_EN
        expect_res("b129", 32'h7FFF_FFFF, 1'b1);
`else
        expect_res("b129", 32'h80FF_FEFE, 1'b0);
`endif

        // Reset in the third resolve cycle.
        beat(24'd9, 24'd9, 1'b0);
        beat(24'd9, 24'd9, 1'b1);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b1; #1;
        check("rst_mid_res", 64'({ready_o, valid_o}), 64'b10);
        @(negedge clk_i); rst_i = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk_i); if (valid_o) n++; end
        check("rst_no_valid", 64'(n), 64'd0);
        @(posedge clk_i); #1;
        tot = 0;
        beat(24'd1, 24'd1, 1'b1);
        expect_res("rst_next", 32'h0000_0002, 1'b0);

        for (int g = 0; g < 6; g++) rand_group($sformatf("rand%0d", g), int'($urandom_range(1, 6)));

        // Back-to-back stream with valid_i and ready_i held high.
        begin
            logic [IN_SIZE-1:0] bs[$], bc[$];
            logic               bl[$];
            logic [32:0]        exp_q[$];
            int idx, got, cyc, ng;
            logic acc;
            ng = 5;
            tot = 0;
            for (int g = 0; g < ng; g++) begin
                n = int'($urandom_range(1, 4));
                for (int i = 0; i < n; i++) begin
                    bs.push_back(24'($urandom)); bc.push_back(24'($urandom));
                    bl.push_back(i == n - 1);
                    tot += sx(bs[$]) + sx(bc[$]);
                end
                exp_q.push_back(model(tot));
                tot = 0;
            end
            idx = 0; got = 0; cyc = 0;
            ready_i = 1'b1;
            while (got < ng && cyc < 500) begin
                if (idx < bs.size()) begin
                    sum_i = bs[idx]; carry_i = bc[idx]; last_i = bl[idx]; valid_i = 1'b1;
                end else begin
                    valid_i = 1'b0; last_i = 1'b0;
                end
                acc = ready_o && valid_i;
                if (valid_o) begin
                    check($sformatf("stream_g%0d", got), 64'({sat_o, result_o}), 64'(exp_q[got]));
                    got++;
                end
                @(posedge clk_i); #1;
                if (acc) idx++;
                cyc++;
            end
            valid_i = 1'b0; ready_i = 1'b0;
            check("stream_done", 64'({got, idx}), 64'({ng, bs.size()}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/carry_save_resolver.md
# carry_save_resolver

Sequential back end for the compressor-tree datapath. It accepts a stream of redundant (sum, carry) pairs, accumulates them in carry-save form over a group of beats, and closes the group with a multi-cycle chunked carry-propagate addition. The result is presented as a single signed two's-complement value behind a valid/ready handshake. It sits directly downstream of the 12:2 compression stage in the MAC path.

## Interface
- IN_SIZE, 24, width of each incoming sum/carry operand (signed)
- ACC_SIZE, 32, width of resolved result
- CHUNK, 8, bits resolved per cycle in the carry-propagate phase
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- sum_i  in  IN_SIZE  redundant sum operand
- carry_i  in  IN_SIZE  redundant carry operand, already aligned (no shift applied here)
- last_i  in  1  marks final beat of a group
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat
- result_o  out  ACC_SIZE  resolved signed group sum
- sat_o  out  1  result was saturated (see Configuration)
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result

## Operation
- Internal width W = ACC_SIZE+2 (two guard bits).
- Registers: acc_s, acc_c (W each), chunk counter, carry-in flop, result register.
- States:
  - ACC: ready_o=1. On each accepted beat (valid_i && ready_o), sum_i and carry_i are sign-extended to W. {acc_s, acc_c, sum, carry} are compressed 4:2. The new carry is shifted left by 1, and everything is taken mod 2^W. A beat with last_i moves the FSM to RES. Otherwise it stays in ACC.
  - RES: ready_o=0. Each cycle adds one CHUNK slice of acc_s+acc_c plus the carry flop, writes that slice of the result, and increments the counter. After N=ceil(W/CHUNK) cycles the FSM moves to OUT. The top slice is truncated to W.
  - OUT: valid_o=1, ready_o=0. On ready_i the FSM returns to ACC, and acc_s, acc_c, counter and carry are cleared in that same edge.
- A group with a single beat is legal.
- valid_i is ignored outside ACC.
- Arithmetic is mod 2^W. Overflow beyond the guard bits is not detected.

## Timing
- Reset values: ready_o=1, valid_o=0, result_o=0, sat_o=0, state=ACC, all accumulators 0.
- Last beat accepted on edge t: RES occupies edges t+1..t+N, and valid_o is high from after edge t+N. With defaults W=34, N=5, so the first result cycle is 6 cycles after the last-beat cycle.
- result_o and sat_o are stable while valid_o=1 && !ready_i.
- ready_o rises the cycle after the output handshake.
- Reset asserted in any state takes effect immediately. The in-flight group is discarded, with no partial output.

## Configuration
- RESOLVER_SAT_EN defined:
  - After resolve, if the W-bit value lies outside the signed ACC_SIZE range, result_o is clamped to 2^(ACC_SIZE-1)-1 or -2^(ACC_SIZE-1).
  - sat_o=1 for that result.
  - The clamp is applied in the final RES cycle, so latency does not change.
- Undefined:
  - result_o is the low ACC_SIZE bits (wrap).
  - sat_o is tied 0.

## Structure
- Package resolver_pkg holds:
  - the state typedef (ACC, RES, OUT);
  - GUARD_BITS=2;
  - a function returning N from W and CHUNK.
- The accumulate step instantiates the existing compressor_4_2_n_bit (INPUT_WIDTH=W, SHIFT_CARRY=1), with its output truncated to W.
- No other sub-module is needed.

## Test plan
- Single beat sum=5, carry=3, last=1 -> result_o=0x00000008, valid_o 6 cycles after acceptance, sat_o=0.
- Three beats (0xFFFFFF,0xFFFFFE), (10,0), (0,4), last on the third -> -3+10+4 = 0x0000000B. ready_o is low from the cycle after the third beat until the output handshake.
- Backpressure: hold ready_i=0 for 3 cycles in OUT -> result_o and valid_o stable, beats offered on valid_i are not accepted, and ready_o=1 the cycle after ready_i rises.
- 129 beats of (0x7FFFFF,0x7FFFFF):
  - with RESOLVER_SAT_EN -> 0x7FFFFFFF, sat_o=1;
  - without -> 0x80FFFEFE, sat_o=0.
  - The same test with 128 beats -> 0x7FFFFF00, sat_o=0.
- Assert rst_i during the third RES cycle -> valid_o never rises and ready_o=1 immediately. The next single-beat group (1,1) returns 0x00000002 with no leftover state.
- Back-to-back groups, with ready_i=1 and valid_i held high -> each result equals only its own group's sum, and no beat is lost or double counted.
